// File: rtl/c16_snd_pkg.sv
// Shared constants and helpers for the c16 sound block.
package c16_snd_pkg;

  typedef enum logic [1:0] {
    P_PERIOD = 2'd0,
    P_VOL    = 2'd1,
    P_DUR    = 2'd2,
    P_WAVE   = 2'd3
  } param_e;

  localparam int          NUM_CH    = 4;
  localparam logic [15:0] DUR_INF   = 16'hFFFF;
  localparam logic [14:0] LFSR_SEED = 15'h0001;

  // Taps x^15 + x^14 + 1: new bit enters at bit 0.
  function automatic logic [14:0] lfsr_next(input logic [14:0] s);
    return {s[13:0], s[14] ^ s[13]};
  endfunction

endpackage

// File: rtl/c16_snd_channel.sv
// One tone/noise channel: registers, phase counter, LFSR, output level and
// duration countdown.
module c16_snd_channel
  import c16_snd_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        wen,
  input  logic [1:0]  param,
  input  logic [15:0] val,
  input  logic        s_tick,
  input  logic        d_tick,
  output logic        active,
  output logic [3:0]  contrib
);

  logic [15:0] period;
  logic [3:0]  vol;
  logic [15:0] dur;
  logic        wave;
  logic [15:0] phase;
  logic [14:0] lfsr;
  logic        level;
  logic [14:0] lfsr_nx;
  logic        wrap;

  assign lfsr_nx = lfsr_next(lfsr);
  assign wrap    = ({1'b0, phase} + 17'd1) >= {1'b0, period};
  assign contrib = level ? vol : 4'd0;

  // Later assignments override earlier ones: sample tick, then duration
  // expiry, then the CPU write for the fields it touches.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      period <= '0;
      vol    <= '0;
      dur    <= '0;
      wave   <= 1'b0;
      phase  <= '0;
      lfsr   <= LFSR_SEED;
      level  <= 1'b0;
      active <= 1'b0;
    end else begin
      if (s_tick && active && (period != 16'd0)) begin
        if (wrap) begin
          phase <= '0;
          if (wave) begin
            lfsr  <= lfsr_nx;
            level <= lfsr_nx[0];
          end else begin
            level <= ~level;
          end
        end else begin
          phase <= phase + 16'd1;
        end
      end

      if (d_tick && active && (dur != 16'd0) && (dur != DUR_INF)) begin
        dur <= dur - 16'd1;
        if (dur == 16'd1) begin
          active <= 1'b0;
          level  <= 1'b0;
          phase  <= '0;
        end
      end

      if (wen) begin
        case (param)
          P_PERIOD: begin
            period <= val;
            phase  <= '0;
          end
          P_VOL: vol <= val[3:0];
          P_DUR: begin
            dur    <= val;
            active <= (val != 16'd0);
            if (val == 16'd0) begin
              level <= 1'b0;
              phase <= '0;
            end
          end
          P_WAVE: wave <= val[0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/c16_snd.sv
// Four-channel tone/noise generator fed by the c16 sound write port; mixes
// to an 8-bit sample and a 1-bit PWM pin.
module c16_snd
  import c16_snd_pkg::*;
#(
  parameter int SAMPLE_DIV = 1136,
  parameter int DUR_DIV    = 50000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        snd_wen,
  input  logic [1:0]  w_param,
  input  logic [10:0] w_index,
  input  logic [15:0] w_val,
  output logic [7:0]  sample,
  output logic        sample_valid,
  output logic        pwm_out,
  output logic [3:0]  active
);

  localparam int SW = $clog2(SAMPLE_DIV);
  localparam int DW = $clog2(DUR_DIV);

  logic [SW-1:0]           s_cnt;
  logic [DW-1:0]           d_cnt;
  logic                    s_tick;
  logic                    d_tick;
  logic                    tick_d1;
  logic                    wr_ok;
  logic [NUM_CH-1:0]       ch_wen;
  logic [NUM_CH-1:0][3:0]  contrib;
  logic [5:0]              sum;
  logic [7:0]              pwm_cnt;

  assign s_tick = (s_cnt == SW'(SAMPLE_DIV - 1));
  assign d_tick = (d_cnt == DW'(DUR_DIV - 1));
  assign wr_ok  = snd_wen && (w_index[10:2] == 9'd0);

  always_comb begin
    ch_wen = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_wen[i] = wr_ok && (w_index[1:0] == 2'(i));
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
    c16_snd_channel u_ch (
      .clk     (clk),
      .resetn  (resetn),
      .wen     (ch_wen[i]),
      .param   (w_param),
      .val     (w_val),
      .s_tick  (s_tick),
      .d_tick  (d_tick),
      .active  (active[i]),
      .contrib (contrib[i])
    );
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = sum + 6'(contrib[i]);
    end
  end

  // Channels settle at the end of the tick cycle; the mix is captured one
  // cycle later so sample and its strobe line up.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s_cnt        <= '0;
      d_cnt        <= '0;
      tick_d1      <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      pwm_cnt      <= '0;
      pwm_out      <= 1'b0;
    end else begin
      s_cnt        <= s_tick ? '0 : s_cnt + 1'b1;
      d_cnt        <= d_tick ? '0 : d_cnt + 1'b1;
      tick_d1      <= s_tick;
      sample_valid <= tick_d1;
      if (tick_d1) sample <= {sum, 2'b00};
      pwm_cnt      <= pwm_cnt + 8'd1;
      pwm_out      <= (pwm_cnt < sample);
    end
  end

endmodule

// File: tb/tb_c16_snd.sv
// Self-checking bench for c16_snd: spec-level channel model feeding a sample
// scoreboard, a table of decode vectors, and hand-written corner sequences.
module tb_c16_snd;
  import c16_snd_pkg::*;

  localparam int SD = 4;
  localparam int DD = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        snd_wen = 1'b0;
  logic [1:0]  w_param = '0;
  logic [10:0] w_index = '0;
  logic [15:0] w_val = '0;
  logic [7:0]  sample;
  logic        sample_valid;
  logic        pwm_out;
  logic [3:0]  active;

  c16_snd #(.SAMPLE_DIV(SD), .DUR_DIV(DD)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .snd_wen      (snd_wen),
    .w_param      (w_param),
    .w_index      (w_index),
    .w_val        (w_val),
    .sample       (sample),
    .sample_valid (sample_valid),
    .pwm_out      (pwm_out),
    .active       (active)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  // Reference model state, advanced on each rising edge.
  logic [15:0] m_period[4];
  logic [15:0] m_dur[4];
  logic [15:0] m_phase[4];
  logic [3:0]  m_vol[4];
  logic        m_wave[4];
  logic        m_level[4];
  logic        m_active[4];
  logic [14:0] m_lfsr[4];
  int          m_scnt = 0;
  int          m_dcnt = 0;
  logic        m_tick_d = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_mix();
    int s = 0;
    for (int c = 0; c < 4; c++) if (m_level[c]) s += int'(m_vol[c]);
    return 8'(s * 4);
  endfunction

  task automatic model_step();
    logic s_tick, d_tick, wr;
    logic [15:0] np, nd;
    logic nl, na;
    logic [14:0] nlf;
    if (!resetn) begin
      for (int c = 0; c < 4; c++) begin
        m_period[c] = '0; m_dur[c] = '0; m_phase[c] = '0; m_vol[c] = '0;
        m_wave[c] = 1'b0; m_level[c] = 1'b0; m_active[c] = 1'b0; m_lfsr[c] = 15'h0001;
      end
      m_scnt = 0; m_dcnt = 0; m_tick_d = 1'b0;
      exp_q.delete();
    end else begin
      if (m_tick_d) exp_q.push_back(model_mix());
      s_tick   = (m_scnt == SD - 1);
      d_tick   = (m_dcnt == DD - 1);
      m_tick_d = s_tick;
      m_scnt   = s_tick ? 0 : m_scnt + 1;
      m_dcnt   = d_tick ? 0 : m_dcnt + 1;
      for (int c = 0; c < 4; c++) begin
        wr  = snd_wen && (w_index[10:2] == 9'd0) && (w_index[1:0] == 2'(c));
        np  = m_phase[c]; nl = m_level[c]; nlf = m_lfsr[c];
        nd  = m_dur[c];   na = m_active[c];
        if (s_tick && m_active[c] && m_period[c] != 0) begin
          if (int'(m_phase[c]) + 1 >= int'(m_period[c])) begin
            np = 0;
            if (m_wave[c]) begin
              nlf = {m_lfsr[c][13:0], m_lfsr[c][14] ^ m_lfsr[c][13]};
              nl  = nlf[0];
            end else nl = ~m_level[c];
          end else np = m_phase[c] + 1;
        end
        if (d_tick && m_active[c] && m_dur[c] != 0 && m_dur[c] != 16'hFFFF) begin
          nd = m_dur[c] - 1;
          if (nd == 0) begin na = 0; nl = 0; np = 0; end
        end
        if (wr) begin
          case (w_param)
            2'd0: begin m_period[c] = w_val; np = 0; end
            2'd1: m_vol[c] = w_val[3:0];
            2'd2: begin
              nd = w_val; na = (w_val != 0);
              if (w_val == 0) begin nl = 0; np = 0; end
            end
            default: m_wave[c] = w_val[0];
          endcase
        end
        m_phase[c] = np; m_level[c] = nl; m_lfsr[c] = nlf; m_dur[c] = nd; m_active[c] = na;
      end
    end
  endtask

  always @(posedge clk) model_step();

  // Scoreboard: every expected sample must appear with its strobe, and no
  // strobe may appear without an expected sample.
  always @(negedge clk) begin
    if (sample_valid || exp_q.size() != 0) begin
      check("sample_valid", {31'd0, sample_valid}, {31'd0, exp_q.size() != 0});
      if (sample_valid && exp_q.size() != 0) check("sample", sample, exp_q.pop_front());
      exp_q.delete();
    end
  end

  // Drivers assume they are called at a falling edge.
  task automatic wr(input logic [1:0] p, input logic [10:0] idx, input logic [15:0] v);
    snd_wen = 1'b1; w_param = p; w_index = idx; w_val = v;
    @(negedge clk);
    snd_wen = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cycles(3);
    resetn = 1'b1;
  endtask

  task automatic wait_scnt(input int v);
    int k = 0;
    while (m_scnt != v && k < 100) begin @(negedge clk); k++; end
    if (k >= 100) check("wait_scnt_timeout", m_scnt, v);
  endtask

  typedef struct {
    logic [1:0]  p;
    logic [10:0] idx;
    logic [15:0] v;
    logic [3:0]  exp_act;
  } vec_t;
  vec_t vecs[10];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, cnt;
    vecs[0] = '{P_DUR, 11'd4,     16'd5,     4'h0};
    vecs[1] = '{P_DUR, 11'h400,   16'd5,     4'h0};
    vecs[2] = '{P_DUR, 11'd0,     16'hFFFF,  4'h1};
    vecs[3] = '{P_DUR, 11'h7FF,   16'd0,     4'h1};
    vecs[4] = '{P_DUR, 11'd3,     16'hFFFF,  4'h9};
    vecs[5] = '{P_DUR, 11'h403,   16'd0,     4'h9};
    vecs[6] = '{P_VOL, 11'h404,   16'd15,    4'h9};
    vecs[7] = '{P_DUR, 11'd3,     16'd0,     4'h1};
    vecs[8] = '{P_DUR, 11'd2,     16'd7,     4'h5};
    vecs[9] = '{P_DUR, 11'd0,     16'd0,     4'h4};

    // Reset values
    @(negedge clk);
    do_reset();
    check("rst_sample", sample, 8'd0);
    check("rst_valid", sample_valid, 1'b0);
    check("rst_pwm", pwm_out, 1'b0);
    check("rst_active", active, 4'h0);

    // ch0 square, period 2: strobe every SD clocks, sample 0/60 alternation
    wr(P_VOL, 11'd0, 16'd15);
    wr(P_PERIOD, 11'd0, 16'd2);
    wr(P_DUR, 11'd0, 16'hFFFF);
    check("t1_active", active, 4'h1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (sample_valid) cnt++; end
    check("t1_valid_count", cnt, 40 / SD);

    // All four channels in lock-step, then frozen high for a PWM window
    do_reset();
    for (int c = 0; c < 4; c++) begin wr(P_VOL, 11'(c), 16'd15); wr(P_PERIOD, 11'(c), 16'd1); end
    wait_scnt(0);
    for (int c = 0; c < 4; c++) wr(P_DUR, 11'(c), 16'hFFFF);
    check("t2_active", active, 4'hF);
    for (int c = 0; c < 4; c++) begin
      k = 0;
      while (!(m_scnt != SD - 1 && m_level[c]) && k < 50) begin @(negedge clk); k++; end
      if (k >= 50) check("t2_level_timeout", {31'd0, m_level[c]}, 1);
      wr(P_PERIOD, 11'(c), 16'd1000);
    end
    cycles(12);
    check("t2_sample_max", sample, 8'd240);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin @(negedge clk); if (pwm_out) cnt++; end
    check("t2_pwm_high", cnt, 240);

    // Finite duration on ch1
    do_reset();
    wr(P_PERIOD, 11'd1, 16'd1);
    wr(P_VOL, 11'd1, 16'd8);
    wr(P_DUR, 11'd1, 16'd3);
    check("t3_active", active, 4'h2);
    k = 0;
    while (active[1] && k < 60) begin @(negedge clk); k++; end
    check("t3_expired", active, 4'h0);
    check("t3_expiry_window", {31'd0, (k >= 17 && k <= 24)}, 1);
    cycles(8);
    check("t3_sample_zero", sample, 8'd0);

    // Noise on ch2 over 100 sample ticks
    do_reset();
    wr(P_WAVE, 11'd2, 16'd1);
    wr(P_PERIOD, 11'd2, 16'd1);
    wr(P_VOL, 11'd2, 16'd1);
    wr(P_DUR, 11'd2, 16'hFFFF);
    cycles(100 * SD);
    check("t4_lfsr", dut.gen_ch[2].u_ch.lfsr, m_lfsr[2]);

    // Decode table: out-of-range indices must change nothing
    do_reset();
    wr(P_PERIOD, 11'd0, 16'd1);
    for (int i = 0; i < 10; i++) begin
      wr(vecs[i].p, vecs[i].idx, vecs[i].v);
      check($sformatf("t5_vec%0d_active", i), active, vecs[i].exp_act);
    end
    cycles(8);
    check("t5_sample", sample, 8'd0);

    // Period write coinciding with a sample tick, then reset mid-note
    do_reset();
    wr(P_VOL, 11'd0, 16'd15); wr(P_PERIOD, 11'd0, 16'd5); wr(P_DUR, 11'd0, 16'hFFFF);
    wr(P_VOL, 11'd3, 16'd15); wr(P_PERIOD, 11'd3, 16'd5); wr(P_DUR, 11'd3, 16'hFFFF);
    cycles(9);
    k = 0;
    while (!(m_scnt == SD - 1 && m_phase[0] < 4 && m_phase[3] < 4) && k < 100) begin
      @(negedge clk); k++;
    end
    if (k >= 100) check("t6_align_timeout", m_scnt, SD - 1);
    wr(P_PERIOD, 11'd0, 16'd5);
    check("t6_ch0_phase", dut.gen_ch[0].u_ch.phase, 16'd0);
    check("t6_ch3_phase", dut.gen_ch[3].u_ch.phase, m_phase[3]);
    cycles(20);
    resetn = 1'b0;
    @(negedge clk);
    check("t6_rst_sample", sample, 8'd0);
    check("t6_rst_valid", sample_valid, 1'b0);
    check("t6_rst_pwm", pwm_out, 1'b0);
    check("t6_rst_active", active, 4'h0);
    resetn = 1'b1;
    cycles(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
